// File: rtl/sgpr_retire_matcher.sv
// sgpr_retire_matcher: per-slot SGPR operand pending tracker cleared by multi-port retires.
// Define SGPR_MATCH_WRAP_EN to make operand/retire address sums wrap modulo 2^ADDR_W.
module sgpr_retire_matcher #(
   parameter int NUM_OPS   = 6,
   parameter int OPW       = 4,
   parameter int NUM_RET   = 2,
   parameter int RET_WORDS = 4,
   parameter int ADDR_W    = 9
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [NUM_OPS-1:0]          load_op_valid,
   input  logic [NUM_OPS*ADDR_W-1:0]   load_op_addr,
   input  logic [NUM_OPS*2-1:0]        load_op_size,
   input  logic [NUM_OPS*OPW-1:0]      load_pending,
   input  logic [NUM_RET-1:0]          retire_valid,
   input  logic [NUM_RET*ADDR_W-1:0]   retire_addr,
   input  logic [NUM_RET*RET_WORDS-1:0] retire_mask,
   input  logic                        issue,
   input  logic                        flush,
   output logic [NUM_OPS*OPW-1:0]      pending,
   output logic                        ready,
   output logic                        clear_hit
);
`ifdef SGPR_MATCH_WRAP_EN
   localparam int SW = ADDR_W;
`else
   localparam int SW = ADDR_W + 2;
`endif
   localparam int PW = NUM_OPS * OPW;

   typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;

   state_t                    state, state_nxt;
   logic [PW-1:0]             op_mask, op_mask_nxt, ld_mask, cmp_mask, cur_pend, pend_nxt, clr;
   logic [NUM_OPS*ADDR_W-1:0] op_addr, op_addr_nxt, cmp_addr;
   logic                      load_acc, hit;

   function automatic logic [OPW-1:0] word_mask(input logic [1:0] s);
      logic [3:0] m;
      m = (s == 2'b01) ? 4'b0011 : (s == 2'b10) ? ((OPW == 4) ? 4'b1111 : 4'b0011) : 4'b0001;
      return m[OPW-1:0];
   endfunction

   always_comb begin
      ld_mask = '0;
      for (int i = 0; i < NUM_OPS; i++)
         ld_mask[i*OPW +: OPW] = load_op_valid[i] ? word_mask(load_op_size[i*2 +: 2]) : '0;
   end

   assign load_ready = state == EMPTY;
   assign ready      = state == READY;
   assign load_acc   = load_valid && load_ready && !flush;
   // An accepted load is compared against this cycle's retires so no wakeup is lost.
   assign cmp_mask   = load_acc ? ld_mask : op_mask;
   assign cmp_addr   = load_acc ? load_op_addr : op_addr;
   assign cur_pend   = load_acc ? (load_pending & ld_mask) : pending;

   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_OPS; i++)
         for (int j = 0; j < OPW; j++)
            for (int k = 0; k < NUM_RET; k++)
               for (int w = 0; w < RET_WORDS; w++)
                  if (retire_valid[k] && retire_mask[k*RET_WORDS+w] && cmp_mask[i*OPW+j] &&
                      (SW'(cmp_addr[i*ADDR_W +: ADDR_W]) + SW'(j) ==
                       SW'(retire_addr[k*ADDR_W +: ADDR_W]) + SW'(w)))
                     clr[i*OPW+j] = 1'b1;
   end

   always_comb begin
      pend_nxt    = cur_pend & ~clr;
      hit         = |(cur_pend & clr);
      state_nxt   = state;
      op_addr_nxt = op_addr;
      op_mask_nxt = op_mask;
      if (flush) begin
         state_nxt = EMPTY;
         pend_nxt  = '0;
         hit       = 1'b0;
      end else if (state == READY && issue) begin
         state_nxt = EMPTY;
      end else if (load_acc) begin
         state_nxt   = (pend_nxt == '0) ? READY : WAIT;
         op_addr_nxt = load_op_addr;
         op_mask_nxt = ld_mask;
      end else if (state == WAIT && pend_nxt == '0) begin
         state_nxt = READY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         pending   <= '0;
         clear_hit <= 1'b0;
         op_addr   <= '0;
         op_mask   <= '0;
      end else begin
         state     <= state_nxt;
         pending   <= pend_nxt;
         clear_hit <= hit;
         op_addr   <= op_addr_nxt;
         op_mask   <= op_mask_nxt;
      end
   end
endmodule

// File: tb/tb_sgpr_retire_matcher.sv
// tb_sgpr_retire_matcher: directed scoreboard bench for sgpr_retire_matcher.
module tb_sgpr_retire_matcher;
   logic        clk = 1'b0;
   logic        rst, load_valid, load_ready, issue, flush, ready, clear_hit;
   logic [5:0]  load_op_valid;
   logic [53:0] load_op_addr;
   logic [11:0] load_op_size;
   logic [23:0] load_pending, pending;
   logic [1:0]  retire_valid;
   logic [17:0] retire_addr;
   logic [7:0]  retire_mask;

   typedef struct {
      string       tag;
      logic [23:0] pend;
      logic        rdy;
      logic        lrdy;
      logic        hit;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sgpr_retire_matcher dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_op_valid(load_op_valid), .load_op_addr(load_op_addr), .load_op_size(load_op_size),
      .load_pending(load_pending), .retire_valid(retire_valid), .retire_addr(retire_addr),
      .retire_mask(retire_mask), .issue(issue), .flush(flush), .pending(pending),
      .ready(ready), .clear_hit(clear_hit)
   );

   task automatic idle();
      load_valid = 0; load_op_valid = '0; load_op_addr = '0; load_op_size = '0;
      load_pending = '0; retire_valid = '0; retire_addr = '0; retire_mask = '0;
      issue = 0; flush = 0;
   endtask

   task automatic set_op(input int i, input logic v, input logic [8:0] a, input logic [1:0] s,
                         input logic [3:0] p);
      load_op_valid[i]       = v;
      load_op_addr[i*9 +: 9] = a;
      load_op_size[i*2 +: 2] = s;
      load_pending[i*4 +: 4] = p;
   endtask

   task automatic set_ret(input int k, input logic [8:0] a, input logic [3:0] m);
      retire_valid[k]       = 1'b1;
      retire_addr[k*9 +: 9] = a;
      retire_mask[k*4 +: 4] = m;
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (pending === e.pend) else begin
         errors++;
         $error("FAIL %s pending: got %h expected %h", e.tag, pending, e.pend);
      end
      checks++;
      assert (ready === e.rdy) else begin
         errors++;
         $error("FAIL %s ready: got %b expected %b", e.tag, ready, e.rdy);
      end
      checks++;
      assert (load_ready === e.lrdy) else begin
         errors++;
         $error("FAIL %s load_ready: got %b expected %b", e.tag, load_ready, e.lrdy);
      end
      checks++;
      assert (clear_hit === e.hit) else begin
         errors++;
         $error("FAIL %s clear_hit: got %b expected %b", e.tag, clear_hit, e.hit);
      end
   endtask

   task automatic step(input string tag, input logic [23:0] p, input logic r, input logic lr,
                       input logic h);
      exp_t e;
      e.tag = tag; e.pend = p; e.rdy = r; e.lrdy = lr; e.hit = h;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      @(posedge clk);
      step("reset", 24'h0, 0, 1, 0);
      rst = 0;
      // basic clear
      load_valid = 1; set_op(0, 1, 9'd10, 2'b10, 4'b1111);
      step("load_op0", 24'h00000F, 0, 0, 0);
      set_ret(0, 9'd12, 4'b0011);
      step("basic_clear", 24'h000003, 0, 0, 1);
      set_ret(0, 9'd10, 4'b0011); set_ret(1, 9'd12, 4'b0011);
      step("two_port", 24'h0, 1, 0, 1);
      step("hit_pulse_end", 24'h0, 1, 0, 0);
      issue = 1;
      step("issue", 24'h0, 0, 1, 0);
      // load/retire bypass
      load_valid = 1; set_op(1, 1, 9'd40, 2'b01, 4'b0011); set_ret(0, 9'd39, 4'b0110);
      step("bypass", 24'h0, 1, 0, 1);
      issue = 1;
      step("issue2", 24'h0, 0, 1, 0);
      // invalid and 1-word operands
      load_valid = 1;
      set_op(2, 0, 9'd20, 2'b10, 4'b1111); set_op(3, 1, 9'd20, 2'b00, 4'b1111);
      step("masked_load", 24'h001000, 0, 0, 0);
      load_valid = 1; issue = 1; set_op(0, 1, 9'd10, 2'b10, 4'b1111);
      step("wait_ignores", 24'h001000, 0, 0, 0);
      set_ret(0, 9'd20, 4'b1111);
      step("invalid_op", 24'h0, 1, 0, 1);
      issue = 1;
      step("issue3", 24'h0, 0, 1, 0);
      // top-of-space wrap
      load_valid = 1; set_op(0, 1, 9'd510, 2'b10, 4'b1111);
      step("load_wrap", 24'h00000F, 0, 0, 0);
      set_ret(0, 9'd0, 4'b0011);
`ifdef SGPR_MATCH_WRAP_EN
      step("wrap", 24'h000003, 0, 0, 1);
`else
      step("no_wrap", 24'h00000F, 0, 0, 0);
`endif
      // flush beats load
      flush = 1; load_valid = 1; set_op(4, 1, 9'd60, 2'b00, 4'b0001);
      step("flush", 24'h0, 0, 1, 0);
      step("flush_idle", 24'h0, 0, 1, 0);
      // reset mid-WAIT drops in-flight retires
      load_valid = 1; set_op(5, 1, 9'd100, 2'b01, 4'b0011);
      step("load_op5", 24'h300000, 0, 0, 0);
      rst = 1; set_ret(0, 9'd100, 4'b0011);
      step("mid_reset", 24'h0, 0, 1, 0);
      rst = 0;
      step("post_reset", 24'h0, 0, 1, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
